// File: rtl/calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// calc_cmd_sequencer
//   Command front-end and mode controller for the calculator datapath.
//   Debounces the four push-buttons, accepts IR key codes, merges both sources
//   into one-hot pending requests, serves one request per cycle by priority
//   (OnOff > Soma > Sub > Mult) and steps the Off/Soma/Sub/Mult/On mode FSM.
//
//   Ports
//     CLK       in   1   system clock, rising edge
//     Reset     in   1   asynchronous active-low reset (release synchronised)
//     B1..B4    in   1   raw active-low buttons: B1=Soma B2=Sub B3=Mult B4=On/Off
//     IR_Data   in  16   IR key code
//     IR_Valid  in   1   IR_Data holds a complete frame (level)
//     IR_Clr    out  1   active-low one-cycle clear pulse to the IR decoder
//     Estado    out  3   mode: Off=0 Soma=1 Sub=2 Mult=3 On=4
//     Cmd       out  4   one-hot command served this cycle {OnOff,Mult,Sub,Soma}
//     Op_Load   out  1   pulse when Estado enters Soma/Sub/Mult
//
//   Build option
//     CALC_IR_EN  defined: IR path active. Undefined: IR inputs ignored,
//                 IR_Clr held at 1, no IR logic.
// -----------------------------------------------------------------------------
module calc_cmd_sequencer #(
    parameter int          DEB_CYCLES = 16,
    parameter int          CNT_W      = 16,
    parameter logic [15:0] CODE_ONOFF = 16'h8d72,
    parameter logic [15:0] CODE_SOMA  = 16'h8e71,
    parameter logic [15:0] CODE_SUB   = 16'h9c63,
    parameter logic [15:0] CODE_MULT  = 16'h9e61
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        B1,
    input  logic        B2,
    input  logic        B3,
    input  logic        B4,
    input  logic [15:0] IR_Data,
    input  logic        IR_Valid,
    output logic        IR_Clr,
    output logic [2:0]  Estado,
    output logic [3:0]  Cmd,
    output logic        Op_Load
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Command bit positions, shared by Cmd, pending and request vectors
    localparam int C_SOMA  = 0;
    localparam int C_SUB   = 1;
    localparam int C_MULT  = 2;
    localparam int C_ONOFF = 3;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_SOMA = 3'd1,
        ST_SUB  = 3'd2,
        ST_MULT = 3'd3,
        ST_ON   = 3'd4
    } mode_e;

    logic [1:0]       rst_sync_q;
    logic             rst_n_s;
    logic [3:0]       btn_raw_s;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [3:0]       deb_prev_q;
    logic [3:0]       btn_req_s;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       ir_req_s;
    logic [3:0]       pend_q;
    logic [3:0]       pend_d;
    logic [3:0]       serve_s;
    logic [3:0]       cmd_q;
    logic [3:0]       cmd_d;
    mode_e            state_q;
    mode_e            state_d;
    mode_e            op_mode_s;
    logic             op_load_q;
    logic             op_load_d;

    // Reset synchroniser: assertion is immediate, release is aligned to CLK
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s   = rst_sync_q[1];
    assign btn_raw_s = {B4, B3, B2, B1};

    // Debounce: count consecutive cycles where synced level differs from the
    // accepted level; a release (0->1 of the accepted level) raises a request
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = CNT_ZERO;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = CNT_ZERO;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = CNT_ZERO;
            end
        end
        btn_req_s = deb_q & ~deb_prev_q;
    end

`ifdef CALC_IR_EN
    logic ir_busy_q;
    logic ir_busy_d;
    logic ir_clr_q;
    logic ir_clr_d;

    // IR handshake: decode once per frame, pulse the clear, then wait for
    // IR_Valid to drop so a stuck level yields a single request
    always_comb begin
        ir_req_s  = 4'b0000;
        ir_busy_d = ir_busy_q;
        ir_clr_d  = 1'b1;
        if (!ir_busy_q && IR_Valid) begin
            ir_busy_d = 1'b1;
            ir_clr_d  = 1'b0;
            case (IR_Data)
                CODE_ONOFF: ir_req_s = 4'b1000;
                CODE_SOMA:  ir_req_s = 4'b0001;
                CODE_SUB:   ir_req_s = 4'b0010;
                CODE_MULT:  ir_req_s = 4'b0100;
                default:    ir_req_s = 4'b0000;
            endcase
        end else if (!IR_Valid) begin
            ir_busy_d = 1'b0;
        end else begin
            ir_busy_d = ir_busy_q;
        end
    end

    // IR handshake registers
    always_ff @(posedge CLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            ir_busy_q <= 1'b0;
            ir_clr_q  <= 1'b1;
        end else begin
            ir_busy_q <= ir_busy_d;
            ir_clr_q  <= ir_clr_d;
        end
    end

    assign IR_Clr = ir_clr_q;
`else
    logic unused_ir_s;
    assign unused_ir_s = ^{IR_Data, IR_Valid};
    assign ir_req_s    = 4'b0000;
    assign IR_Clr      = 1'b1;
`endif

    // Arbitration and mode transitions; requests arriving this cycle are
    // merged into pending and served from the next cycle on
    always_comb begin
        if (pend_q[C_ONOFF]) begin
            serve_s = 4'b1000;
        end else if (pend_q[C_SOMA]) begin
            serve_s = 4'b0001;
        end else if (pend_q[C_SUB]) begin
            serve_s = 4'b0010;
        end else if (pend_q[C_MULT]) begin
            serve_s = 4'b0100;
        end else begin
            serve_s = 4'b0000;
        end
        pend_d = (pend_q & ~serve_s) | btn_req_s | ir_req_s;

        if (serve_s[C_SOMA]) begin
            op_mode_s = ST_SOMA;
        end else if (serve_s[C_SUB]) begin
            op_mode_s = ST_SUB;
        end else begin
            op_mode_s = ST_MULT;
        end

        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                // operation commands are consumed without leaving Off
                if (serve_s[C_ONOFF]) begin
                    state_d = ST_ON;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_ON: begin
                if (serve_s[C_ONOFF]) begin
                    state_d = ST_OFF;
                end else if (serve_s != 4'b0000) begin
                    state_d = op_mode_s;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_SOMA, ST_SUB, ST_MULT: begin
                // repeating the active operation toggles back to On
                if (serve_s[C_ONOFF]) begin
                    state_d = ST_OFF;
                end else if (serve_s != 4'b0000) begin
                    state_d = (op_mode_s == state_q) ? ST_ON : op_mode_s;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        op_load_d = ((state_d == ST_SOMA) || (state_d == ST_SUB) || (state_d == ST_MULT))
                    && (state_d != state_q);
        cmd_d     = serve_s;
    end

    // Main state: synchronisers, debouncers, pending bits and mode FSM
    always_ff @(posedge CLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sync1_q    <= 4'b1111;
            sync2_q    <= 4'b1111;
            deb_q      <= 4'b1111;
            deb_prev_q <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            pend_q     <= 4'b0000;
            state_q    <= ST_OFF;
            cmd_q      <= 4'b0000;
            op_load_q  <= 1'b0;
        end else begin
            sync1_q    <= btn_raw_s;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q     <= pend_d;
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            op_load_q  <= op_load_d;
        end
    end

    assign Estado  = state_q;
    assign Cmd     = cmd_q;
    assign Op_Load = op_load_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_cmd_sequencer
//   Directed scenarios plus randomized button/IR traffic. A behavioural model
//   (sample-window debounce, pending set, priority pick, mode table) predicts
//   Cmd/Estado/Op_Load/IR_Clr every cycle; directed checks use constants.
//   Honours CALC_IR_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_calc_cmd_sequencer;

    localparam int DEB = 16;

    logic        CLK      = 1'b0;
    logic        Reset    = 1'b0;
    logic        B1       = 1'b1;
    logic        B2       = 1'b1;
    logic        B3       = 1'b1;
    logic        B4       = 1'b1;
    logic [15:0] IR_Data  = 16'h0000;
    logic        IR_Valid = 1'b0;
    logic        IR_Clr;
    logic [2:0]  Estado;
    logic [3:0]  Cmd;
    logic        Op_Load;

    calc_cmd_sequencer dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .B1       (B1),
        .B2       (B2),
        .B3       (B3),
        .B4       (B4),
        .IR_Data  (IR_Data),
        .IR_Valid (IR_Valid),
        .IR_Clr   (IR_Clr),
        .Estado   (Estado),
        .Cmd      (Cmd),
        .Op_Load  (Op_Load)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [3:0] m_deb      = 4'hF;
    logic [3:0] m_pend     = 4'h0;
    logic [3:0] m_rel_prev = 4'h0;
    logic [3:0] m_cmd      = 4'h0;
    int         m_state    = 0;
    bit         m_opld     = 1'b0;
    bit         m_clr      = 1'b1;
    bit         m_busy     = 1'b0;
    int         act_cnt    = 0;
    logic [3:0] hist[$];
    logic [3:0] served, rel_now, irq, pins;
    int         ns;
    bit         all_diff;

    function automatic logic [3:0] pick(input logic [3:0] p);
        if (p[3]) return 4'b1000;
        if (p[0]) return 4'b0001;
        if (p[1]) return 4'b0010;
        if (p[2]) return 4'b0100;
        return 4'b0000;
    endfunction

    function automatic int next_mode(input int s, input logic [3:0] c);
        int op;
        if (c == 4'b0000) return s;
        if (c[3]) return (s == 0) ? 4 : 0;
        op = c[0] ? 1 : (c[1] ? 2 : 3);
        if (s == 0) return 0;
        if (s == 4) return op;
        return (op == s) ? 4 : op;
    endfunction

    function automatic logic [3:0] ir_code(input logic [15:0] d);
        case (d)
            16'h8d72: return 4'b1000;
            16'h8e71: return 4'b0001;
            16'h9c63: return 4'b0010;
            16'h9e61: return 4'b0100;
            default:  return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_deb = 4'hF; m_pend = 4'h0; m_rel_prev = 4'h0; m_cmd = 4'h0;
        m_state = 0; m_opld = 1'b0; m_clr = 1'b1; m_busy = 1'b0;
        hist.delete();
        repeat (20) hist.push_back(4'hF);
    endtask

    // Model step per rising edge; reset takes effect immediately
    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            model_reset();
            act_cnt = 0;
        end else if (act_cnt < 2) begin
            act_cnt++;
        end else begin
            pins   = {B4, B3, B2, B1};
            served = pick(m_pend);
            ns     = next_mode(m_state, served);
            m_opld = (ns >= 1) && (ns <= 3) && (ns != m_state);
            m_state = ns;
            m_cmd   = served;
            irq     = 4'b0000;
`ifdef CALC_IR_EN
            if (!m_busy && IR_Valid) begin
                m_busy = 1'b1;
                m_clr  = 1'b0;
                irq    = ir_code(IR_Data);
            end else begin
                m_clr = 1'b1;
                if (!IR_Valid) m_busy = 1'b0;
            end
`else
            m_clr = 1'b1;
`endif
            // a level is accepted once the pin samples taken 2..17 edges ago
            // all disagree with the currently accepted level
            rel_now = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int j = 2; j < 2 + DEB; j++) begin
                    if (hist[hist.size() - j][b] == m_deb[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_deb[b] = ~m_deb[b];
                    if (m_deb[b]) rel_now[b] = 1'b1;
                end
            end
            m_pend     = (m_pend & ~served) | m_rel_prev | irq;
            m_rel_prev = rel_now;
            hist.push_back(pins);
            void'(hist.pop_front());
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check_eq("cmd",     32'(Cmd),     32'(m_cmd));
            check_eq("estado",  32'(Estado),  32'(m_state));
            check_eq("op_load", 32'(Op_Load), 32'(m_opld));
            check_eq("ir_clr",  32'(IR_Clr),  32'(m_clr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_pins(input logic [3:0] v);
        {B4, B3, B2, B1} = v;
    endtask

    task automatic press(input logic [3:0] m, input int len);
        set_pins(~m);
        cyc(len);
        set_pins(4'hF);
    endtask

    logic [15:0] codes [5] = '{16'h8d72, 16'h8e71, 16'h9c63, 16'h9e61, 16'h1234};
    int lat, cnt_a, cnt_b, first_i, est1, est2, sel, len;
    logic [15:0] seq;
    logic [3:0]  m;

    initial begin
        // 1: reset and idle
        cyc(4);
        chk_en = 1'b1;
        cyc(2);
        check_eq("rst_estado", 32'(Estado),  32'd0);
        check_eq("rst_cmd",    32'(Cmd),     32'd0);
        check_eq("rst_irclr",  32'(IR_Clr),  32'd1);
        check_eq("rst_opload", 32'(Op_Load), 32'd0);
        Reset = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (Estado != 3'd0 || Cmd != 4'd0 || IR_Clr !== 1'b1 || Op_Load !== 1'b0) cnt_a++;
        end
        check_eq("idle50", 32'(cnt_a), 32'd0);

        // 2: On/Off hold, latency, then Soma toggling
        set_pins(4'b0111);
        cyc(40);
        set_pins(4'hF);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (Cmd == 4'b1000 && lat < 0) lat = i;
        end
        check_eq("b4_latency", 32'(lat), 32'(DEB + 4));
        check_eq("b4_estado",  32'(Estado), 32'd4);
        press(4'b0001, 20);
        cnt_a = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (Op_Load) cnt_a++;
        end
        check_eq("soma_estado", 32'(Estado), 32'd1);
        check_eq("soma_opload", 32'(cnt_a),  32'd1);
        press(4'b0001, 20);
        cnt_a = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (Op_Load) cnt_a++;
        end
        check_eq("soma_off_estado", 32'(Estado), 32'd4);
        check_eq("soma_off_opload", 32'(cnt_a),  32'd0);

        // 3: short glitch is ignored
        press(4'b0010, DEB - 6);
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (Cmd != 4'd0) cnt_a++;
        end
        check_eq("glitch_cmd",    32'(cnt_a),  32'd0);
        check_eq("glitch_estado", 32'(Estado), 32'd4);

        // 4: stuck IR_Valid with Mult code, then an unknown code
        for (int pass = 0; pass < 2; pass++) begin
            IR_Data  = (pass == 0) ? 16'h9e61 : 16'h1234;
            IR_Valid = 1'b1;
            cnt_a = 0; cnt_b = 0; first_i = -1; est1 = -1; est2 = -1;
            for (int i = 1; i <= 35; i++) begin
                @(negedge CLK);
                if (!IR_Clr) begin
                    cnt_a++;
                    if (first_i < 0) first_i = i;
                end
                if (Cmd != 4'd0) cnt_b++;
                if (i == 1) est1 = 32'(Estado);
                if (i == 2) est2 = 32'(Estado);
                if (i == 30) IR_Valid = 1'b0;
            end
`ifdef CALC_IR_EN
            check_eq("ir_clr_count", 32'(cnt_a),   32'd1);
            check_eq("ir_clr_cycle", 32'(first_i), 32'd1);
            check_eq("ir_cmds",      32'(cnt_b),   (pass == 0) ? 32'd1 : 32'd0);
            check_eq("ir_est_c1",    32'(est1),    (pass == 0) ? 32'd4 : 32'd3);
            check_eq("ir_est_c2",    32'(est2),    32'd3);
`else
            check_eq("ir_clr_count", 32'(cnt_a), 32'd0);
            check_eq("ir_cmds",      32'(cnt_b), 32'd0);
            check_eq("ir_est_c2",    32'(est2),  32'd4);
`endif
        end
`ifdef CALC_IR_EN
        press(4'b0100, 20);
        cyc(25);
`endif
        check_eq("pre5_estado", 32'(Estado), 32'd4);

        // 5: Soma and Mult released together, IR On/Off landing the same cycle
        set_pins(4'b1010);
        cyc(30);
        set_pins(4'hF);
        IR_Data = 16'h8d72;
        seq = 16'h0000; cnt_a = 0; first_i = -1; lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (Cmd != 4'd0) begin
                seq = {seq[11:0], Cmd};
                cnt_a++;
                if (first_i < 0) first_i = i;
                lat = i;
            end
            if (i == DEB + 2) IR_Valid = 1'b1;
            if (i == DEB + 7) IR_Valid = 1'b0;
        end
`ifdef CALC_IR_EN
        check_eq("multi_seq",    32'(seq),    32'h0814);
        check_eq("multi_count",  32'(cnt_a),  32'd3);
        check_eq("multi_estado", 32'(Estado), 32'd0);
`else
        check_eq("multi_seq",    32'(seq),    32'h0014);
        check_eq("multi_count",  32'(cnt_a),  32'd2);
        check_eq("multi_estado", 32'(Estado), 32'd3);
`endif
        check_eq("multi_consec", 32'(lat - first_i), 32'(cnt_a - 1));

        // 6: reset mid-debounce and mid-handshake
        set_pins(4'b1110);
        cyc(8);
        IR_Data  = 16'h9c63;
        IR_Valid = 1'b1;
        @(posedge CLK);
        #1;
`ifdef CALC_IR_EN
        check_eq("clr_before_rst", 32'(IR_Clr), 32'd0);
`else
        check_eq("clr_before_rst", 32'(IR_Clr), 32'd1);
`endif
        Reset = 1'b0;
        #1;
        check_eq("arst_estado", 32'(Estado),  32'd0);
        check_eq("arst_cmd",    32'(Cmd),     32'd0);
        check_eq("arst_irclr",  32'(IR_Clr),  32'd1);
        check_eq("arst_opload", 32'(Op_Load), 32'd0);
        @(negedge CLK);
        IR_Valid = 1'b0;
        cyc(3);
        Reset = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Cmd != 4'd0) cnt_a++;
        end
        check_eq("held_no_cmd", 32'(cnt_a), 32'd0);
        set_pins(4'hF);
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (Cmd == 4'b0001) cnt_a++;
        end
        check_eq("held_release_cmd", 32'(cnt_a),  32'd1);
        check_eq("held_estado",      32'(Estado), 32'd0);

        // 7: randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin
                    m   = 4'b0001 << $urandom_range(0, 3);
                    len = $urandom_range(2, 40);
                    press(m, len);
                end
                1: begin
                    m   = 4'($urandom_range(1, 15));
                    len = $urandom_range(10, 30);
                    press(m, len);
                end
                2: begin
                    IR_Data  = ($urandom_range(0, 5) == 5) ? 16'($urandom) : codes[$urandom_range(0, 4)];
                    IR_Valid = 1'b1;
                    cyc($urandom_range(1, 8));
                    IR_Valid = 1'b0;
                    cyc(1);
                end
                default: begin
                    cyc($urandom_range(0, 25));
                end
            endcase
        end
        cyc(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
